// File: rtl/deck_pkg.sv
// rtl/deck_pkg.sv - shared card types, deck geometry and LFSR constants for the card shoe
package deck_pkg;

   typedef enum logic [1:0] {
      SUIT_SPADES   = 2'd0,
      SUIT_HEARTS   = 2'd1,
      SUIT_DIAMONDS = 2'd2,
      SUIT_CLUBS    = 2'd3
   } suit_t;

   typedef struct packed {
      logic [1:0] suit;
      logic [3:0] rank;
      logic [3:0] value;
   } card_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_PROBE = 1'b1
   } state_t;

   localparam int CARDS_PER_DECK = 52;
   localparam int RANKS          = 13;

   // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/card_decode.sv
// rtl/card_decode.sv - maps a position within one deck to suit, rank and game value
// Suit-major ordering: pos/13 selects the suit, pos%13+1 the rank.
module card_decode
   import deck_pkg::*;
#(
   parameter int ACE_VALUE = 11
) (
   input  logic [5:0] pos,
   output card_t      card
);

   logic [5:0] rem;
   logic [3:0] rank;

   always_comb begin
      card = '0;
      rem  = pos;
      if (pos >= 6'd39) begin
         card.suit = SUIT_CLUBS;
         rem       = pos - 6'd39;
      end else if (pos >= 6'd26) begin
         card.suit = SUIT_DIAMONDS;
         rem       = pos - 6'd26;
      end else if (pos >= 6'd13) begin
         card.suit = SUIT_HEARTS;
         rem       = pos - 6'd13;
      end else begin
         card.suit = SUIT_SPADES;
      end
      rank      = rem[3:0] + 4'd1;
      card.rank = rank;
      if (rank == 4'd1) begin
         card.value = 4'(ACE_VALUE);
      end else if (rank > 4'd10) begin
         card.value = 4'd10;
      end else begin
         card.value = rank;
      end
   end

endmodule

// File: rtl/deck_shoe.sv
// rtl/deck_shoe.sv - multi-deck shoe dealing pseudo-random undealt cards on request
// A dealt bit per physical card; a draw probes forward from an LFSR-chosen slot.
module deck_shoe
   import deck_pkg::*;
#(
   parameter int          NUM_DECKS = 1,
   parameter int          ACE_VALUE = 11,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       ready,
   input  logic       draw_req,
   input  logic       shuffle,
   output logic       card_valid,
   output logic [1:0] card_suit,
   output logic [3:0] card_rank,
   output logic [3:0] card_value,
   output logic [2:0] card_deck,
   output logic [8:0] cards_left,
   output logic       empty,
   output logic       empty_err
);

   localparam int         N_SLOTS   = CARDS_PER_DECK * NUM_DECKS;
   localparam int         IW        = $clog2(N_SLOTS);
   localparam logic [8:0] N_CARDS   = 9'(N_SLOTS);
   localparam logic [2:0] DECK_LAST = 3'(NUM_DECKS - 1);

   state_t               state_q, state_d;
   logic [15:0]          lfsr_q;
   logic [N_SLOTS-1:0]   dealt_q;
   logic [8:0]           left_q;
   logic [5:0]           pos_q;
   logic [2:0]           deck_q;
   logic [IW-1:0]        idx;
   logic [5:0]           pos_start;
   logic [2:0]           deck_start;
   logic                 slot_dealt;
   card_t                slot_card;

   logic                 accept, do_shuffle, draw_err, take, advance;

   logic                 valid_q, err_q;
   logic [1:0]           suit_q;
   logic [3:0]           rank_q, value_q;
   logic [2:0]           deck_out_q;

   assign idx        = IW'(int'(deck_q) * CARDS_PER_DECK + int'(pos_q));
   assign slot_dealt = dealt_q[idx];
   assign pos_start  = (lfsr_q[5:0] >= 6'd52) ? (lfsr_q[5:0] - 6'd52) : lfsr_q[5:0];
   // Deck counts are powers of two, so masking keeps the index in range
   assign deck_start = lfsr_q[10:8] & DECK_LAST;

   card_decode #(.ACE_VALUE(ACE_VALUE)) u_decode (
      .pos  (pos_q),
      .card (slot_card)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      do_shuffle = 1'b0;
      draw_err   = 1'b0;
      take       = 1'b0;
      advance    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (shuffle) begin
               do_shuffle = 1'b1;
            end else if (draw_req) begin
               if (left_q == 9'd0) begin
                  draw_err = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = ST_PROBE;
               end
            end
         end
         ST_PROBE: begin
            if (slot_dealt) begin
               advance = 1'b1;
            end else begin
               take    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q     <= LFSR_SEED;
         dealt_q    <= '0;
         left_q     <= N_CARDS;
         pos_q      <= 6'd0;
         deck_q     <= 3'd0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         suit_q     <= 2'd0;
         rank_q     <= 4'd0;
         value_q    <= 4'd0;
         deck_out_q <= 3'd0;
      end else begin
         // Free-running so that request timing perturbs the start slot
         lfsr_q  <= lfsr_next(lfsr_q);
         valid_q <= take;
         err_q   <= draw_err;
         if (do_shuffle) begin
            dealt_q <= '0;
            left_q  <= N_CARDS;
         end
         if (accept) begin
            pos_q  <= pos_start;
            deck_q <= deck_start;
         end
         if (advance) begin
            if (pos_q == 6'(CARDS_PER_DECK - 1)) begin
               pos_q  <= 6'd0;
               deck_q <= (deck_q == DECK_LAST) ? 3'd0 : deck_q + 3'd1;
            end else begin
               pos_q <= pos_q + 6'd1;
            end
         end
         if (take) begin
            dealt_q[idx] <= 1'b1;
            left_q       <= left_q - 9'd1;
            suit_q       <= slot_card.suit;
            rank_q       <= slot_card.rank;
            value_q      <= slot_card.value;
            deck_out_q   <= deck_q;
         end
      end
   end

   assign ready      = (state_q == ST_IDLE);
   assign card_valid = valid_q;
   assign empty_err  = err_q;
   assign card_suit  = suit_q;
   assign card_rank  = rank_q;
   assign card_value = value_q;
   assign card_deck  = deck_out_q;
   assign cards_left = left_q;
   assign empty      = (left_q == 9'd0);

endmodule

// File: tb/tb_deck_shoe.sv
// tb/tb_deck_shoe.sv - scoreboard bench for deck_shoe with one- and two-deck instances
module tb_deck_shoe;

   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       ready      [2];
   logic       draw_req   [2];
   logic       shuffle    [2];
   logic       card_valid [2];
   logic [1:0] card_suit  [2];
   logic [3:0] card_rank  [2];
   logic [3:0] card_value [2];
   logic [2:0] card_deck  [2];
   logic [8:0] cards_left [2];
   logic       empty      [2];
   logic       empty_err  [2];

   deck_shoe #(.NUM_DECKS(1), .ACE_VALUE(11), .LFSR_SEED(SEED)) u_one (
      .clk(clk), .rst_n(rst_n), .ready(ready[0]), .draw_req(draw_req[0]), .shuffle(shuffle[0]),
      .card_valid(card_valid[0]), .card_suit(card_suit[0]), .card_rank(card_rank[0]),
      .card_value(card_value[0]), .card_deck(card_deck[0]), .cards_left(cards_left[0]),
      .empty(empty[0]), .empty_err(empty_err[0])
   );

   deck_shoe #(.NUM_DECKS(2), .ACE_VALUE(1), .LFSR_SEED(SEED)) u_two (
      .clk(clk), .rst_n(rst_n), .ready(ready[1]), .draw_req(draw_req[1]), .shuffle(shuffle[1]),
      .card_valid(card_valid[1]), .card_suit(card_suit[1]), .card_rank(card_rank[1]),
      .card_value(card_value[1]), .card_deck(card_deck[1]), .cards_left(cards_left[1]),
      .empty(empty[1]), .empty_err(empty_err[1])
   );

   typedef struct {
      int due;
      int deck;
      int suit;
      int rank;
      int value;
      int left;
   } exp_t;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int nd [2] = '{1, 2};
   int av [2] = '{11, 1};

   bit          dealt_m [2][416];
   int          seen    [2][416];
   int          left_m  [2];
   bit          busy_m  [2];
   int          busy_end[2];
   int          acc_cnt [2];
   logic [15:0] lfsr_m  [2];

   exp_t cq0[$];
   exp_t cq1[$];
   int   eq0[$];
   int   eq1[$];

   function automatic void chk(string name, int act, int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void cq_push(int i, exp_t e);
      if (i == 0) cq0.push_back(e); else cq1.push_back(e);
   endfunction
   function automatic int cq_size(int i);
      return (i == 0) ? cq0.size() : cq1.size();
   endfunction
   function automatic exp_t cq_pop(int i);
      return (i == 0) ? cq0.pop_front() : cq1.pop_front();
   endfunction
   function automatic int cq_due(int i);
      return (i == 0) ? cq0[0].due : cq1[0].due;
   endfunction
   function automatic void eq_push(int i, int d);
      if (i == 0) eq0.push_back(d); else eq1.push_back(d);
   endfunction
   function automatic int eq_size(int i);
      return (i == 0) ? eq0.size() : eq1.size();
   endfunction
   function automatic int eq_pop(int i);
      return (i == 0) ? eq0.pop_front() : eq1.pop_front();
   endfunction

   function automatic logic [15:0] lfsr_step(logic [15:0] s);
      logic [15:0] t;
      t = s >> 1;
      if (s[0]) t = t ^ 16'hB400;
      return t;
   endfunction

   function automatic void model_clear(int i);
      for (int s = 0; s < 416; s++) dealt_m[i][s] = 1'b0;
      left_m[i] = 52 * nd[i];
   endfunction

   function automatic void clear_seen(int i);
      for (int s = 0; s < 416; s++) seen[i][s] = 0;
   endfunction

   // Reference model: shoe as a flat array of dealt flags, searched by plain arithmetic
   initial begin
      for (int i = 0; i < 2; i++) begin
         lfsr_m[i] = SEED; busy_m[i] = 1'b0; acc_cnt[i] = 0; model_clear(i); clear_seen(i);
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
               lfsr_m[i] = SEED;
               busy_m[i] = 1'b0;
               model_clear(i);
               if (i == 0) begin cq0.delete(); eq0.delete(); end
               else        begin cq1.delete(); eq1.delete(); end
            end else begin
               if (busy_m[i]) begin
                  if (cyc == busy_end[i]) busy_m[i] = 1'b0;
               end else if (shuffle[i]) begin
                  model_clear(i);
               end else if (draw_req[i]) begin
                  acc_cnt[i]++;
                  if (left_m[i] == 0) begin
                     eq_push(i, cyc);
                  end else begin
                     int   pos, dk, sk;
                     exp_t e;
                     pos = int'(lfsr_m[i][5:0]);
                     if (pos >= 52) pos -= 52;
                     dk = int'(lfsr_m[i][10:8]) % nd[i];
                     sk = 0;
                     while (dealt_m[i][dk * 52 + pos]) begin
                        sk++;
                        pos++;
                        if (pos == 52) begin pos = 0; dk = (dk + 1) % nd[i]; end
                     end
                     dealt_m[i][dk * 52 + pos] = 1'b1;
                     left_m[i]--;
                     e.due   = cyc + 1 + sk;
                     e.deck  = dk;
                     e.suit  = pos / 13;
                     e.rank  = pos % 13 + 1;
                     e.value = (e.rank == 1) ? av[i] : ((e.rank > 10) ? 10 : e.rank);
                     e.left  = left_m[i];
                     cq_push(i, e);
                     busy_m[i]   = 1'b1;
                     busy_end[i] = e.due;
                  end
               end
               lfsr_m[i] = lfsr_step(lfsr_m[i]);
            end
         end
      end
   end

   // Monitor: compares whatever the DUTs present against the scoreboard heads
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (card_valid[i]) begin
               if (cq_size(i) == 0) begin
                  chk($sformatf("u%0d spurious card_valid", i), int'(card_valid[i]), 0);
               end else begin
                  exp_t e;
                  int   ix;
                  e = cq_pop(i);
                  chk($sformatf("u%0d card cycle", i), cyc, e.due);
                  chk($sformatf("u%0d card_deck", i), int'(card_deck[i]), e.deck);
                  chk($sformatf("u%0d card_suit", i), int'(card_suit[i]), e.suit);
                  chk($sformatf("u%0d card_rank", i), int'(card_rank[i]), e.rank);
                  chk($sformatf("u%0d card_value", i), int'(card_value[i]), e.value);
                  chk($sformatf("u%0d cards_left", i), int'(cards_left[i]), e.left);
                  chk($sformatf("u%0d empty", i), int'(empty[i]), (e.left == 0) ? 1 : 0);
                  ix = int'(card_deck[i]) * 52 + int'(card_suit[i]) * 13 + int'(card_rank[i]) - 1;
                  if (card_rank[i] >= 4'd1 && card_rank[i] <= 4'd13 && ix < 416) seen[i][ix]++;
               end
            end else if (cq_size(i) > 0 && cq_due(i) < cyc) begin
               chk($sformatf("u%0d card_valid missing", i), int'(card_valid[i]), 1);
               void'(cq_pop(i));
            end
            if (empty_err[i]) begin
               if (eq_size(i) == 0) chk($sformatf("u%0d spurious empty_err", i), int'(empty_err[i]), 0);
               else chk($sformatf("u%0d empty_err cycle", i), cyc, eq_pop(i));
            end else if (eq_size(i) > 0) begin
               chk($sformatf("u%0d empty_err missing", i), int'(empty_err[i]), 1);
               void'(eq_pop(i));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic draw(input int i);
      int a0;
      bit ok;
      a0 = acc_cnt[i];
      ok = 1'b0;
      draw_req[i] = 1'b1;
      for (int k = 0; k < 400 && !ok; k++) begin
         tick(1);
         if (acc_cnt[i] != a0) ok = 1'b1;
      end
      draw_req[i] = 1'b0;
      if (!ok) chk($sformatf("u%0d draw accept timeout", i), 0, 1);
   endtask

   task automatic wait_idle(input int i);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         if (!busy_m[i] && cq_size(i) == 0 && eq_size(i) == 0) ok = 1'b1;
         else tick(1);
      end
      if (!ok) chk($sformatf("u%0d idle timeout", i), 0, 1);
   endtask

   task automatic deal(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         draw(i);
         tick($urandom_range(0, 3));
      end
      wait_idle(i);
   endtask

   function automatic int distinct(int i);
      int c;
      c = 0;
      for (int s = 0; s < 416; s++) if (seen[i][s] == 1) c++;
      return c;
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         draw_req[i] = 1'b0;
         shuffle[i]  = 1'b0;
      end
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;

      @(negedge clk);
      chk("reset ready", int'(ready[0]), 1);
      chk("reset cards_left u0", int'(cards_left[0]), 52);
      chk("reset cards_left u1", int'(cards_left[1]), 104);
      chk("reset empty", int'(empty[0]), 0);
      chk("reset card_valid", int'(card_valid[0]), 0);
      chk("reset empty_err", int'(empty_err[0]), 0);
      chk("reset card fields", int'({card_suit[0], card_rank[0], card_value[0], card_deck[0]}), 0);
      tick(1);

      // Full single deck, then a draw from the empty shoe
      clear_seen(0);
      deal(0, 52);
      chk("u0 full deal distinct", distinct(0), 52);
      for (int s = 0; s < 4; s++) begin
         int c;
         c = 0;
         for (int r = 0; r < 13; r++) c += seen[0][s * 13 + r];
         chk($sformatf("u0 suit %0d count", s), c, 13);
      end
      chk("u0 empty after deal", int'(empty[0]), 1);
      chk("u0 cards_left after deal", int'(cards_left[0]), 0);
      draw(0);
      wait_idle(0);
      chk("u0 cards_left after empty draw", int'(cards_left[0]), 0);

      // Shuffle wins over a simultaneous draw, which is then accepted next cycle
      shuffle[0] = 1'b1;
      tick(1);
      shuffle[0] = 1'b0;
      chk("u0 cards_left after shuffle", int'(cards_left[0]), 52);
      deal(0, 30);
      chk("u0 cards_left after 30", int'(cards_left[0]), 22);
      draw_req[0] = 1'b1;
      shuffle[0]  = 1'b1;
      tick(1);
      shuffle[0] = 1'b0;
      chk("u0 ready while shuffle blocks draw", int'(ready[0]), 1);
      chk("u0 cards_left after shuffle+draw", int'(cards_left[0]), 52);
      tick(1);
      chk("u0 held draw accepted", int'(ready[0]), 0);
      draw_req[0] = 1'b0;
      wait_idle(0);
      chk("u0 cards_left after held draw", int'(cards_left[0]), 51);

      // Two-deck shoe with ACE_VALUE=1
      clear_seen(1);
      deal(1, 104);
      chk("u1 full deal distinct", distinct(1), 104);
      chk("u1 empty after deal", int'(empty[1]), 1);

      // Reset in the middle of a probe for the last card
      shuffle[0] = 1'b1;
      tick(1);
      shuffle[0] = 1'b0;
      deal(0, 51);
      chk("u0 cards_left before abort", int'(cards_left[0]), 1);
      draw(0);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort cards_left u0", int'(cards_left[0]), 52);
      chk("abort cards_left u1", int'(cards_left[1]), 104);
      chk("abort ready", int'(ready[0]), 1);
      tick(1);
      draw(0);
      draw(1);
      wait_idle(0);
      wait_idle(1);
      chk("post-abort cards_left u0", int'(cards_left[0]), 51);
      chk("post-abort cards_left u1", int'(cards_left[1]), 103);

      tick(3);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
